// File: rtl/pitch_pkg.sv
// Constants shared by the pitch-detection front end (magnitude stream) and the
// downstream peak-bin tracker.
package pitch_pkg;

   localparam int FFT_DEPTH      = 4096;
   localparam int FFT_DATA_WIDTH = 48;
   localparam int MAG_WIDTH      = 96;
   localparam int K_WIDTH        = 12;

endpackage

// File: rtl/square_pipe.sv
// Two-stage signed squarer: registers the operand, then registers its full-precision square.
module square_pipe
   import pitch_pkg::*;
#(
   parameter int W = FFT_DATA_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic signed [W-1:0]  x,
   output logic [2*W-1:0]       sq
);

   logic signed [W-1:0]   x_r;
   logic signed [2*W-1:0] sq_r;

   // Operand register followed by product register; the square is never negative.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_r  <= '0;
         sq_r <= '0;
      end else begin
         x_r  <= x;
         sq_r <= x_r * x_r;
      end
   end

   assign sq = $unsigned(sq_r);

endmodule

// File: rtl/magnitude_stream.sv
// Converts complex FFT bins to squared magnitudes tagged with their bin index,
// with frame-last and truncated-frame indications, over a fixed 3-stage pipeline.
module magnitude_stream #(
   parameter int DEPTH      = pitch_pkg::FFT_DEPTH,
   parameter int DATA_WIDTH = pitch_pkg::FFT_DATA_WIDTH,
   parameter int MAG_WIDTH  = pitch_pkg::MAG_WIDTH,
   parameter int K_WIDTH    = pitch_pkg::K_WIDTH
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         fft_valid,
   input  logic                         fft_sof,
   input  logic signed [DATA_WIDTH-1:0] fft_re,
   input  logic signed [DATA_WIDTH-1:0] fft_im,
   output logic                         data_valid,
   output logic [MAG_WIDTH-1:0]         data_out,
   output logic [K_WIDTH-1:0]           k_out,
   output logic                         frame_last,
   output logic                         frame_error
);

   localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(DEPTH - 1);

   logic [K_WIDTH-1:0]   k_in_ctr_r;
   logic [K_WIDTH-1:0]   tag_k_s;
   logic                 sof_err_s;
   logic                 v1_r, v2_r;
   logic                 err1_r, err2_r;
   logic [K_WIDTH-1:0]   k1_r, k2_r;
   logic [MAG_WIDTH-1:0] sq_re_s, sq_im_s, sum_s;

   // Tag the incoming beat; sof forces bin 0 and flags a truncated frame if the counter was mid-frame.
   always_comb begin
      tag_k_s   = k_in_ctr_r;
      sof_err_s = 1'b0;
      if (fft_sof) begin
         tag_k_s   = '0;
         sof_err_s = (k_in_ctr_r != '0);
      end else begin
         tag_k_s   = k_in_ctr_r;
         sof_err_s = 1'b0;
      end
   end

   // Bin counter; the natural K_WIDTH wrap gives silent back-to-back framing.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         k_in_ctr_r <= '0;
      end else if (fft_valid) begin
         k_in_ctr_r <= tag_k_s + K_WIDTH'(1);
      end
   end

   // Sideband delay line aligned with the two squarer stages.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v1_r   <= 1'b0;
         k1_r   <= '0;
         err1_r <= 1'b0;
         v2_r   <= 1'b0;
         k2_r   <= '0;
         err2_r <= 1'b0;
      end else begin
         v1_r   <= fft_valid;
         k1_r   <= tag_k_s;
         err1_r <= fft_valid & sof_err_s;
         v2_r   <= v1_r;
         k2_r   <= k1_r;
         err2_r <= err1_r;
      end
   end

   square_pipe #(.W(DATA_WIDTH)) u_sq_re (
      .clock (clock),
      .reset (reset),
      .x     (fft_re),
      .sq    (sq_re_s)
   );

   square_pipe #(.W(DATA_WIDTH)) u_sq_im (
      .clock (clock),
      .reset (reset),
      .x     (fft_im),
      .sq    (sq_im_s)
   );

   // Each square is at most 2^(2*DATA_WIDTH-2), so the sum cannot overflow MAG_WIDTH.
   assign sum_s = sq_re_s + sq_im_s;

   // Output stage; data and index hold between beats so the consumer never sees a stray index.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_valid  <= 1'b0;
         data_out    <= '0;
         k_out       <= '0;
         frame_last  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         data_valid  <= v2_r;
         frame_last  <= v2_r & (k2_r == K_LAST);
         frame_error <= v2_r & err2_r;
         if (v2_r) begin
            data_out <= sum_s;
            k_out    <= k2_r;
         end
      end
   end

endmodule

// File: tb/tb_magnitude_stream.sv
// Scoreboard bench for magnitude_stream: a reference model queues expected samples at
// drive time; the monitor pops and compares them, and checks that outputs hold between beats.
module tb_magnitude_stream;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               fft_valid = 1'b0;
   logic               fft_sof = 1'b0;
   logic signed [47:0] fft_re = '0;
   logic signed [47:0] fft_im = '0;
   logic               data_valid;
   logic [95:0]        data_out;
   logic [11:0]        k_out;
   logic               frame_last;
   logic               frame_error;

   typedef struct {
      logic [95:0] mag;
      logic [11:0] k;
      logic        last;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [11:0] model_ctr = 12'd0;
   logic [95:0] last_mag = 96'd0;
   logic [11:0] last_k = 12'd0;

   magnitude_stream dut (
      .clock       (clock),
      .reset       (reset),
      .fft_valid   (fft_valid),
      .fft_sof     (fft_sof),
      .fft_re      (fft_re),
      .fft_im      (fft_im),
      .data_valid  (data_valid),
      .data_out    (data_out),
      .k_out       (k_out),
      .frame_last  (frame_last),
      .frame_error (frame_error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] ref_mag(input logic signed [47:0] re, input logic signed [47:0] im);
      logic signed [95:0] r, i;
      r = re;
      i = im;
      return r * r + i * i;
   endfunction

   task automatic drive_x(input logic sof, input logic signed [47:0] re,
                          input logic signed [47:0] im, input logic [95:0] m);
      exp_t e;
      @(posedge clock);
      #1;
      fft_valid = 1'b1;
      fft_sof   = sof;
      fft_re    = re;
      fft_im    = im;
      e.k    = sof ? 12'd0 : model_ctr;
      e.err  = sof && (model_ctr != 12'd0);
      e.last = (e.k == 12'd4095);
      e.mag  = m;
      e.cyc  = cyc;
      model_ctr = e.k + 12'd1;
      sb.push_back(e);
   endtask

   task automatic drive(input logic sof, input logic signed [47:0] re, input logic signed [47:0] im);
      drive_x(sof, re, im, ref_mag(re, im));
   endtask

   task automatic drive_rand(input logic sof);
      logic signed [47:0] re, im;
      re = 48'({$urandom(), $urandom()});
      im = 48'({$urandom(), $urandom()});
      drive(sof, re, im);
   endtask

   // Idle cycles carry garbage data and a stray sof that must all be ignored.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
         fft_valid = 1'b0;
         fft_sof   = 1'($urandom_range(0, 1));
         fft_re    = 48'({$urandom(), $urandom()});
         fft_im    = 48'({$urandom(), $urandom()});
      end
   endtask

   // Monitor: compare each output beat with the scoreboard head; between beats outputs must hold.
   always @(negedge clock) begin
      if (!reset) begin
         if (data_valid) begin
            if (sb.size() == 0) begin
               check_value("spurious_valid", 128'(1), 128'(0));
            end else begin
               mon_e = sb.pop_front();
               check_value("mag", 128'(data_out), 128'(mon_e.mag));
               check_value("k", 128'(k_out), 128'(mon_e.k));
               check_value("last", 128'(frame_last), 128'(mon_e.last));
               check_value("err", 128'(frame_error), 128'(mon_e.err));
               check_value("latency", 128'(cyc), 128'(mon_e.cyc + 3));
            end
            last_mag = data_out;
            last_k   = k_out;
         end else begin
            check_value("hold", {18'd0, data_out, k_out, frame_last, frame_error},
                        {18'd0, last_mag, last_k, 2'b00});
         end
      end
   end

   initial begin
      #2 reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check_value("rst_valid", 128'(data_valid), 128'(0));
      check_value("rst_data", 128'(data_out), 128'(0));
      check_value("rst_k", 128'(k_out), 128'(0));
      check_value("rst_flags", 128'({frame_last, frame_error}), 128'(0));
      reset = 1'b0;

      // Basic sof beat with a hand-computed magnitude.
      drive_x(1'b1, 48'sd3, -48'sd4, 96'd25);
      idle(5);

      // Extremes against exact constants.
      drive_x(1'b0, 48'sh8000_0000_0000, 48'sh8000_0000_0000, 96'h8000_0000_0000_0000_0000_0000);
      drive_x(1'b0, 48'sh7FFF_FFFF_FFFF, 48'sd0, 96'h3FFF_FFFF_FFFF_0000_0000_0001);
      drive_x(1'b0, 48'sh8000_0000_0000, 48'sh7FFF_FFFF_FFFF, 96'h7FFF_FFFF_FFFF_0000_0000_0001);
      idle(4);

      // Two contiguous full frames; the second sof lands exactly on the wrap.
      for (int f = 0; f < 2; f++) begin
         drive_rand(1'b1);
         for (int i = 1; i < 4096; i++) drive_rand(1'b0);
      end
      idle(4);

      // Gapped input: one beat every third cycle.
      for (int i = 0; i < 10; i++) begin
         drive_rand(1'b0);
         idle(2);
      end
      idle(3);

      // Truncated frame: sof arrives at bin 100.
      drive_rand(1'b1);
      for (int i = 1; i < 100; i++) drive_rand(1'b0);
      drive_rand(1'b1);
      for (int i = 0; i < 4; i++) drive_rand(1'b0);
      idle(4);

      // Reset with three beats in flight; they must be dropped.
      drive_rand(1'b0);
      drive_rand(1'b0);
      drive_rand(1'b0);
      @(posedge clock);
      #1;
      fft_valid = 1'b0;
      reset     = 1'b1;
      sb.delete();
      model_ctr = 12'd0;
      last_mag  = 96'd0;
      last_k    = 12'd0;
      @(posedge clock);
      #1;
      check_value("midrst_valid", 128'(data_valid), 128'(0));
      check_value("midrst_data", 128'(data_out), 128'(0));
      @(posedge clock);
      #1;
      reset = 1'b0;
      idle(6);
      drive(1'b0, 48'sd5, 48'sd6);
      idle(6);

      check_value("drain", 128'(sb.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
